// File: rtl/mips_board_pkg.sv
// Board-level constants shared by the input-conditioning logic and its instantiation.
package mips_board_pkg;
  localparam int DEBOUNCE_CYCLES_100MHZ = 500000;
  localparam int SWITCH_WIDTH           = 5;
endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: 2-FF synchroniser, stability counter, level and edge pulses.
module debounce_bit #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      rise   <= 1'b0;
      fall   <= 1'b0;
      // Any sample matching the current level restarts the stability window.
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_2;
        cnt   <= '0;
        rise  <= sync_2;
        fall  <= ~sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH switch/button inputs and keeps a sticky event flag for firmware polling.
module switch_debouncer
  import mips_board_pkg::*;
#(
  parameter int WIDTH         = SWITCH_WIDTH,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             event_clr,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             event_pend
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_in[i]),
      .level(db_out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Set has priority so an edge coinciding with a clear is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_pend <= 1'b0;
    end else if (|(rise | fall)) begin
      event_pend <= 1'b1;
    end else if (event_clr) begin
      event_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a short stability window (4 cycles).
module tb_switch_debouncer;
  localparam int W = 5;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw_in;
  logic         event_clr;
  logic [W-1:0] db_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         event_pend;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] raw;
    logic         clr;
    logic [W-1:0] db;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
    logic         ev;
  } vec_t;

  vec_t vecs[$];

  switch_debouncer #(
    .WIDTH(W),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .event_clr (event_clr),
    .db_out    (db_out),
    .rise      (rise),
    .fall      (fall),
    .event_pend(event_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e_db, input logic [W-1:0] e_rs,
                         input logic [W-1:0] e_fl, input logic e_ev);
    chk({tag, ".db_out"}, db_out, e_db);
    chk({tag, ".rise"}, rise, e_rs);
    chk({tag, ".fall"}, fall, e_fl);
    chk({tag, ".event_pend"}, W'(event_pend), W'(e_ev));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [W-1:0] r, input logic c, input logic [W-1:0] d,
                     input logic [W-1:0] rs, input logic [W-1:0] fl, input logic ev, input int n);
    vec_t v;
    v.raw = r; v.clr = c; v.db = d; v.rs = rs; v.fl = fl; v.ev = ev;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    // Reset release with all inputs high, then full fall, then clean press on bit 0.
    add(5'h1F, 0, 5'h00, 5'h00, 5'h00, 0, 5);
    add(5'h1F, 0, 5'h1F, 5'h1F, 5'h00, 0, 1);
    add(5'h1F, 0, 5'h1F, 5'h00, 5'h00, 1, 1);
    add(5'h1F, 1, 5'h1F, 5'h00, 5'h00, 0, 1);
    add(5'h00, 0, 5'h1F, 5'h00, 5'h00, 0, 5);
    add(5'h00, 0, 5'h00, 5'h00, 5'h1F, 0, 1);
    add(5'h00, 0, 5'h00, 5'h00, 5'h00, 1, 1);
    add(5'h00, 1, 5'h00, 5'h00, 5'h00, 0, 1);
    add(5'h01, 0, 5'h00, 5'h00, 5'h00, 0, 5);
    add(5'h01, 0, 5'h01, 5'h01, 5'h00, 0, 1);
    add(5'h01, 0, 5'h01, 5'h00, 5'h00, 1, 1);

    rst = 1'b1;
    raw_in = 5'h1F;
    event_clr = 1'b0;
    repeat (3) step();
    chk_all("reset", 5'h00, 5'h00, 5'h00, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      raw_in = vecs[i].raw;
      event_clr = vecs[i].clr;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].db, vecs[i].rs, vecs[i].fl, vecs[i].ev);
    end

    // Bounce on bit 2: toggling every 2 clks never reaches db_out.
    event_clr = 1'b1;
    step();
    event_clr = 1'b0;
    for (int c = 0; c < 20; c++) begin
      raw_in = ((c % 4) < 2) ? 5'h05 : 5'h01;
      step();
      chk_all("bounce", 5'h01, 5'h00, 5'h00, 0);
    end
    raw_in = 5'h05;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_all("bounce_hold", 5'h01, 5'h00, 5'h00, 0);
    end
    step();
    chk_all("bounce_accept", 5'h05, 5'h04, 5'h00, 0);
    step();
    chk_all("bounce_after", 5'h05, 5'h00, 5'h00, 1);

    // Glitch on bit 1 of only 3 cycles is rejected.
    event_clr = 1'b1;
    step();
    event_clr = 1'b0;
    raw_in = 5'h07;
    repeat (3) step();
    raw_in = 5'h05;
    for (int c = 0; c < 8; c++) begin
      step();
      chk_all("glitch", 5'h05, 5'h00, 5'h00, 0);
    end

    // Bring bit 3 high, clear, then collide event_clr with its fall pulse.
    raw_in = 5'h0D;
    repeat (7) step();
    chk("b3_up", db_out, 5'h0D);
    event_clr = 1'b1;
    step();
    event_clr = 1'b0;
    chk("b3_clr", W'(event_pend), W'(1'b0));
    raw_in = 5'h05;
    repeat (5) step();
    step();
    chk_all("fall3", 5'h05, 5'h00, 5'h08, 0);
    event_clr = 1'b1;
    step();
    chk_all("clr_vs_set", 5'h05, 5'h00, 5'h00, 1);
    event_clr = 1'b0;
    step();
    chk("ev_hold", W'(event_pend), W'(1'b1));
    event_clr = 1'b1;
    step();
    event_clr = 1'b0;
    chk("ev_lone_clr", W'(event_pend), W'(1'b0));

    // Reset mid-count: bit 4 rising, reset after 3 clks, full re-debounce after release.
    raw_in = 5'h15;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 5'h00, 5'h00, 5'h00, 0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_all("rst_relatch", 5'h00, 5'h00, 5'h00, 0);
    end
    step();
    chk_all("rst_rise", 5'h15, 5'h15, 5'h00, 0);
    step();
    chk_all("rst_after", 5'h15, 5'h00, 5'h00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
